// File: rtl/uart_pkg.sv
// Shared UART types and helpers: TX state encoding, bit-period math, line idle level.
// UART_TX_PARITY_EN adds the PARITY state used by the even-parity TX option.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop
`ifdef UART_TX_PARITY_EN
        , StParity
`endif
    } tx_state_e;

    localparam logic LineIdle = 1'b1;

    function automatic int unsigned calc_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-push / status interface of the buffered UART transmitter.
interface uart_tx_fifo_if;

    logic [7:0] din;
    logic       din_rdy;
    logic       tx;
    logic       full;
    logic       busy;
    logic       overflow;

    modport master (
        output din,
        output din_rdy,
        input  tx,
        input  full,
        input  busy,
        input  overflow
    );

    modport slave (
        input  din,
        input  din_rdy,
        output tx,
        output full,
        output busy,
        output overflow
    );

endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered occupancy count; a push into a full FIFO is
// still accepted when a pop happens on the same edge, otherwise it is dropped.
module uart_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [Width-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [Width-1:0]           o_rdata,
    output logic [$clog2(Depth):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_drop
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wptr;
    logic [PtrW-1:0]  r_rptr;
    logic [CntW-1:0]  r_count;
    logic             w_pop_ok;
    logic             w_accept;

    assign o_full   = (r_count == CntW'(Depth));
    assign o_empty  = (r_count == '0);
    assign w_pop_ok = i_pop & ~o_empty;
    assign w_accept = i_push & (~o_full | w_pop_ok);
    assign o_drop   = i_push & ~w_accept;
    assign o_rdata  = r_mem[r_rptr];
    assign o_count  = r_count;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + PtrW'(1);
            end
            unique case ({w_accept, w_pop_ok})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter; define UART_TX_PARITY_EN for an even-parity bit
// between bit7 and the stop bit (11-bit frames).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input logic           clk,
    input logic           rst_n,
    uart_tx_fifo_if.slave bus
);

    localparam int unsigned Div   = calc_div(CLK_FREQ, BAUD);
    localparam int unsigned CntW  = cnt_width(Div);
    localparam int unsigned FCntW = $clog2(FIFO_DEPTH) + 1;

    tx_state_e        r_state, w_state_d;
    logic [CntW-1:0]  r_cnt, w_cnt_d;
    logic [2:0]       r_bit, w_bit_d;
    logic [7:0]       r_shift, w_shift_d;
    logic             r_tx, w_tx_d;
    logic             r_busy;
    logic             r_overflow;
`ifdef UART_TX_PARITY_EN
    logic             r_par, w_par_d;
`endif

    logic [7:0]       w_head;
    logic [FCntW-1:0] w_count;
    logic [FCntW-1:0] w_count_nxt;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;
    logic             w_pop;
    logic             w_push_acc;
    logic             w_cnt_end;

    uart_fifo #(
        .Width (8),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (bus.din_rdy),
        .i_wdata (bus.din),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    assign w_cnt_end   = (r_cnt == CntW'(Div - 1));
    assign w_push_acc  = bus.din_rdy & ~w_drop;
    assign w_count_nxt = w_count + FCntW'(w_push_acc) - FCntW'(w_pop);

    assign bus.tx       = r_tx;
    assign bus.full     = w_full;
    assign bus.busy     = r_busy;
    assign bus.overflow = r_overflow;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_bit_d   = r_bit;
        w_shift_d = r_shift;
        w_tx_d    = r_tx;
        w_pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_d   = r_par;
`endif
        unique case (r_state)
            StIdle: begin
                w_tx_d = LineIdle;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_d = w_head;
`ifdef UART_TX_PARITY_EN
                    w_par_d   = ^w_head;
`endif
                    w_tx_d    = 1'b0;
                    w_cnt_d   = '0;
                    w_state_d = StStart;
                end
            end
            StStart: begin
                w_cnt_d = r_cnt + CntW'(1);
                if (w_cnt_end) begin
                    w_cnt_d   = '0;
                    w_bit_d   = '0;
                    w_tx_d    = r_shift[0];
                    w_shift_d = {1'b0, r_shift[7:1]};
                    w_state_d = StData;
                end
            end
            StData: begin
                w_cnt_d = r_cnt + CntW'(1);
                if (w_cnt_end) begin
                    w_cnt_d = '0;
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_d    = r_par;
                        w_state_d = StParity;
`else
                        w_tx_d    = LineIdle;
                        w_state_d = StStop;
`endif
                    end else begin
                        w_bit_d   = r_bit + 3'd1;
                        w_tx_d    = r_shift[0];
                        w_shift_d = {1'b0, r_shift[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                w_cnt_d = r_cnt + CntW'(1);
                if (w_cnt_end) begin
                    w_cnt_d   = '0;
                    w_tx_d    = LineIdle;
                    w_state_d = StStop;
                end
            end
`endif
            StStop: begin
                w_cnt_d = r_cnt + CntW'(1);
                if (w_cnt_end) begin
                    w_cnt_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!w_empty) begin
                        w_pop     = 1'b1;
                        w_shift_d = w_head;
`ifdef UART_TX_PARITY_EN
                        w_par_d   = ^w_head;
`endif
                        w_tx_d    = 1'b0;
                        w_state_d = StStart;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: begin
                w_tx_d    = LineIdle;
                w_cnt_d   = '0;
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_tx       <= LineIdle;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_bit      <= w_bit_d;
            r_shift    <= w_shift_d;
            r_tx       <= w_tx_d;
            r_busy     <= (w_state_d != StIdle) || (w_count_nxt != '0);
            r_overflow <= r_overflow | w_drop;
`ifdef UART_TX_PARITY_EN
            r_par      <= w_par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=10, depth 16; a line decoder collects frames.
module tb_uart_tx_fifo;

    localparam int unsigned Div   = 10;
    localparam int unsigned Depth = 16;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned FrameBits = 11;
`else
    localparam int unsigned FrameBits = 10;
`endif
    localparam int unsigned Frame = FrameBits * Div;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLK_FREQ   (1000000),
        .BAUD       (100000),
        .FIFO_DEPTH (Depth)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned cyc = 0;
    int unsigned full_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.full === 1'b1) full_cnt <= full_cnt + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  rx_q[$];
    int unsigned rx_t[$];
    logic        rx_p[$];

    // Line decoder: start detect, mid-bit sampling, stop-bit check.
    initial begin : decoder
        logic [7:0]  b;
        logic        p;
        int unsigned t0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.tx === 1'b0) begin
                t0 = cyc;
                repeat (Div / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (Div) @(negedge clk);
                    b[i] = bus.tx;
                end
                p = 1'b0;
`ifdef UART_TX_PARITY_EN
                repeat (Div) @(negedge clk);
                p = bus.tx;
`endif
                repeat (Div) @(negedge clk);
                if (rst_n === 1'b1) check_eq("stop_bit", bus.tx, 1);
                rx_q.push_back(b);
                rx_t.push_back(t0);
                rx_p.push_back(p);
            end
        end
    end

    task automatic clear_rx();
        rx_q.delete();
        rx_t.delete();
        rx_p.delete();
    endtask

    task automatic do_reset();
        bus.din_rdy = 1'b0;
        bus.din     = 8'h00;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One push per call; back-to-back calls push on consecutive edges.
    task automatic push_one(input logic [7:0] b);
        bus.din     = b;
        bus.din_rdy = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_end();
        bus.din_rdy = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned max_cyc, input string tag);
        int unsigned n = 0;
        while ((bus.busy !== 1'b0 || bus.tx !== 1'b1) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, bus.busy, 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int unsigned t_push, k, werr, slot, guard, lows;
        logic [7:0]  b;
        logic        e;
        string       msg;

        bus.din     = 8'h00;
        bus.din_rdy = 1'b0;
        rst_n       = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_tx", bus.tx, 1);
        check_eq("rst_full", bus.full, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_ovf", bus.overflow, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_tx", bus.tx, 1);

        // Single byte: exact waveform, latency and busy fall.
        clear_rx();
        b = 8'h48;
        push_one(b);
        push_end();
        t_push = cyc;
        check_eq("single_busy_rise", bus.busy, 1);
        check_eq("single_tx_before", bus.tx, 1);
        werr = 0;
        for (int t = 0; t < int'(Frame); t++) begin
            @(negedge clk);
            slot = t / Div;
            if (slot == 0) e = 1'b0;
            else if (slot <= 8) e = b[slot-1];
`ifdef UART_TX_PARITY_EN
            else if (slot == 9) e = ^b;
`endif
            else e = 1'b1;
            if (bus.tx !== e) werr++;
        end
        check_eq("single_wave_errs", werr, 0);
        check_eq("single_busy_last", bus.busy, 1);
        @(negedge clk);
        check_eq("single_busy_fall", bus.busy, 0);
        check_eq("single_ovf", bus.overflow, 0);
        check_eq("single_rx_n", rx_q.size(), 1);
        if (rx_q.size() > 0) begin
            check_eq("single_rx_byte", rx_q[0], 8'h48);
            check_eq("single_latency", rx_t[0] - t_push, 1);
        end

        // Burst of 15 bytes: back-to-back frames, FIFO never fills.
        clear_rx();
        msg = "Hello, world!\r\n";
        k = full_cnt;
        for (int i = 0; i < msg.len(); i++) push_one(msg[i]);
        push_end();
        t_push = cyc - 14;
        wait_drain(20 * Frame, "burst_drain");
        check_eq("burst_full_seen", full_cnt - k, 0);
        check_eq("burst_rx_n", rx_q.size(), 15);
        if (rx_q.size() == 15) begin
            check_eq("burst_first_start", rx_t[0] - t_push, 1);
            check_eq("burst_span", rx_t[14] - rx_t[0], 14 * Frame);
            for (int i = 0; i < 15; i++) begin
                check_eq($sformatf("burst_byte%0d", i), rx_q[i], msg[i]);
                if (i > 0) check_eq($sformatf("burst_gap%0d", i), rx_t[i] - rx_t[i-1], Frame);
            end
        end
        check_eq("burst_ovf", bus.overflow, 0);

        // Overflow: 18 pushes, the last one is dropped.
        do_reset();
        clear_rx();
        k = full_cnt;
        for (int i = 0; i < 17; i++) push_one(8'(i));
        check_eq("ovf_full_at17", bus.full, 1);
        check_eq("ovf_clear_at17", bus.overflow, 0);
        push_one(8'h11);
        push_end();
        check_eq("ovf_set", bus.overflow, 1);
        check_eq("ovf_full_seen", (full_cnt != k), 1);
        wait_drain(20 * Frame, "ovf_drain");
        check_eq("ovf_sticky", bus.overflow, 1);
        check_eq("ovf_rx_n", rx_q.size(), 17);
        if (rx_q.size() == 17)
            for (int i = 0; i < 17; i++) check_eq($sformatf("ovf_byte%0d", i), rx_q[i], 8'(i));

        // Push exactly on the pop edge while full: accepted, no overflow.
        do_reset();
        clear_rx();
        for (int i = 0; i < 17; i++) push_one(8'h20 + 8'(i));
        push_end();
        k = cyc - 16;
        guard = 0;
        while (cyc != k + Frame && guard < 2 * Frame) begin
            @(negedge clk);
            guard++;
        end
        check_eq("sim_full_before", bus.full, 1);
        push_one(8'h31);
        push_end();
        check_eq("sim_ovf", bus.overflow, 0);
        check_eq("sim_full_after", bus.full, 1);
        wait_drain(22 * Frame, "sim_drain");
        check_eq("sim_ovf_end", bus.overflow, 0);
        check_eq("sim_rx_n", rx_q.size(), 18);
        if (rx_q.size() == 18)
            for (int i = 0; i < 18; i++) check_eq($sformatf("sim_byte%0d", i), rx_q[i], 8'h20 + 8'(i));

        // Reset during bit3 of 0xA5 with three bytes queued.
        do_reset();
        push_one(8'hA5);
        push_one(8'h01);
        push_one(8'h02);
        push_one(8'h03);
        push_end();
        k = cyc - 3;
        guard = 0;
        while (cyc != k + 1 + 4 * Div + Div / 2 && guard < 2 * Frame) begin
            @(negedge clk);
            guard++;
        end
        check_eq("rmf_bit3_low", bus.tx, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rmf_tx", bus.tx, 1);
        check_eq("rmf_busy", bus.busy, 0);
        check_eq("rmf_full", bus.full, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * Frame) @(negedge clk);
        clear_rx();
        lows = 0;
        for (int t = 0; t < int'(4 * Frame); t++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) lows++;
        end
        check_eq("rmf_no_frame", lows, 0);
        check_eq("rmf_rx_n", rx_q.size(), 0);
        check_eq("rmf_busy_idle", bus.busy, 0);
        push_one(8'h5A);
        push_end();
        wait_drain(2 * Frame, "rmf_drain");
        check_eq("rmf_after_n", rx_q.size(), 1);
        if (rx_q.size() == 1) check_eq("rmf_after_byte", rx_q[0], 8'h5A);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0.
        clear_rx();
        push_one(8'h07);
        push_one(8'h03);
        push_end();
        wait_drain(3 * Frame, "par_drain");
        check_eq("par_rx_n", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check_eq("par_byte0", rx_q[0], 8'h07);
            check_eq("par_bit0", rx_p[0], 1);
            check_eq("par_byte1", rx_q[1], 8'h03);
            check_eq("par_bit1", rx_p[1], 0);
            check_eq("par_frame_len", rx_t[1] - rx_t[0], 110);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Host-side UART transmitter: accepts bytes on a single-cycle strobe interface and buffers them in an internal FIFO.
- Serialises each byte as an 8N1 frame on the tx line.
- Sits downstream of the I/O controller. It absorbs that controller's burst output (up to 15 consecutive strobe cycles per message) without loss, then drains at line rate.
- Counterpart of the existing UART receiver that feeds the controller's din/din_rdy.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. Bit period DIV = CLK_FREQ/BAUD (integer division); DIV >= 2 required; default 868.
- FIFO_DEPTH, 16, byte slots; power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  8  byte to transmit.
- din_rdy  input  1  push strobe; every cycle it is high, din is pushed (level = one push per cycle).
- tx  output  1  serial line, idle high.
- full  output  1  FIFO holds FIFO_DEPTH bytes.
- busy  output  1  FSM not IDLE or FIFO non-empty.
- overflow  output  1  sticky; set when a push is dropped.

Behaviour:
- Reset (rst_n low, async):
  - tx=1, full=0, busy=0, overflow=0.
  - FIFO emptied; FSM=IDLE; baud counter and bit index cleared.
  - Reset mid-frame aborts the frame: tx goes high immediately, no completion.
- FIFO:
  - Synchronous, registered count 0..FIFO_DEPTH.
  - Push accepted when din_rdy=1 and (count<FIFO_DEPTH or a pop occurs the same edge).
  - Push while full with no pop: byte dropped, overflow<=1 until reset.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count!=0 at an edge: pop head into shift register, tx<=0, go START, baud counter=0.
  - Latency: a byte pushed into an empty FIFO at edge N gives tx low after edge N+1.
  - START: hold tx=0 for DIV cycles, then load bit0 and go DATA.
  - DATA: 8 bits LSB first, each held exactly DIV cycles; bit index 0..7. After bit7 go STOP, tx=1.
  - STOP: tx=1 for DIV cycles. On the last cycle: if count!=0, pop and go START directly (no idle gap); else go IDLE.
- Frame timing: frame = 10*DIV cycles; baud counter counts 0..DIV-1 and wraps.
- Status outputs: full = (count==FIFO_DEPTH); busy registered from state and count.
- din_rdy during a frame never disturbs the frame in progress.
- tx is driven from a flop (glitch-free).

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is sent after bit7 in an extra PARITY state for DIV cycles, then STOP. Frame = 11*DIV cycles.
- Undefined: 8N1 as above; PARITY state absent.

Decomposition:
- Package uart_pkg:
  - tx state enum (IDLE/START/DATA/STOP/PARITY).
  - DIV computation function and baud counter width ($clog2(DIV)).
  - Line idle level constant.
- Sub-module uart_fifo: parameterised synchronous FIFO with count, full/empty, push/pop; reused later on the RX side.
- FSM and baud counter stay in uart_tx_fifo.

Test Plan (CLK_FREQ=1000000, BAUD=100000, DIV=10, FIFO_DEPTH=16):
- Single byte: push 0x48 at edge N -> tx low from N+1 for 10 cycles. Then bits 0,0,0,1,0,0,1,0 (10 cycles each), then stop 1. busy drops after 100 cycles; overflow=0.
- Burst: push "Hello, world!\r\n" (15 bytes) on 15 consecutive cycles -> 15 frames back-to-back, 1500 cycles, no idle gap. Decoded bytes match in order; full never asserts.
- Overflow: 18 consecutive pushes 0x00..0x11 -> byte 0x11 dropped, overflow=1 and sticky. full seen high. Bytes 0x00..0x10 transmitted in order.
- Simultaneous push/pop when full: fill 16 bytes, push on the exact STOP-end pop edge -> push accepted, overflow stays 0, count stays 16.
- Reset mid-frame: assert rst_n=0 during DATA bit3 of 0xA5 with 3 bytes queued -> tx=1 immediately, busy=0, full=0. After release no frame appears until a new push.
- With UART_TX_PARITY_EN: push 0x07 -> parity bit 1 after bit7, frame 110 cycles; push 0x03 -> parity bit 0.
